// File: rtl/audio_pkg.sv
// Shared definitions for the audio stream sequencer: codec word width,
// sequencer state encoding and the stereo sample pair.
package audio_pkg;

  localparam int unsigned AUDIO_DATA_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    RECV  = 2'd2,
    WRITE = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [AUDIO_DATA_W-1:0] left;
    logic [AUDIO_DATA_W-1:0] right;
  } stereo_t;

endpackage

// File: rtl/audio_stream_sequencer_sat_counter.sv
// Event counter with synchronous clear; optionally sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH    = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      count <= '0;
    end else if (inc && !(SATURATE && (&count))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/audio_stream_sequencer.sv
// Moves one stereo sample at a time from the codec ADC FIFO, through an
// optional DSP stage, into the codec DAC FIFO, with timeout and statistics.
module audio_stream_sequencer
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W  = AUDIO_DATA_W,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              enable,
  input  logic              bypass,
  input  logic              mute,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  input  logic              write_ready,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic              proc_out_valid,
  input  logic              proc_out_ready,
  output logic [DATA_W-1:0] proc_out_left,
  output logic [DATA_W-1:0] proc_out_right,
  input  logic              proc_in_valid,
  output logic              proc_in_ready,
  input  logic [DATA_W-1:0] proc_in_left,
  input  logic [DATA_W-1:0] proc_in_right,
  output logic              busy,
  output logic [CNT_W-1:0]  sample_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int unsigned     TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } pair_t;

  seq_state_t       state, state_nxt;
  pair_t            sample, wdata;
  logic [TMR_W-1:0] timer;
  logic             tmr_expired;
  logic             capture;
  logic             drop_inc;
  logic             write_inc;

  assign tmr_expired = (timer == TMR_LAST);
  assign capture     = (state == IDLE) && enable && read_ready;
  assign write_inc   = (state == WRITE) && write_ready;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A completed RECV handshake takes priority over an expiring timer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (capture) state_nxt = bypass ? WRITE : SEND;
      SEND:    if (tmr_expired) state_nxt = IDLE;
               else if (proc_out_ready) state_nxt = RECV;
      RECV:    if (proc_in_valid) state_nxt = WRITE;
               else if (tmr_expired) state_nxt = IDLE;
      WRITE:   if (write_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != IDLE);
    proc_out_valid = (state == SEND);
    proc_in_ready  = (state == RECV);
    drop_inc       = ((state == SEND) && tmr_expired) ||
                     ((state == RECV) && tmr_expired && !proc_in_valid);
  end

  // Strobes are registered, so each one is high for the cycle after the
  // edge at which the FSM committed to the pop or push.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      sample <= '0;
      wdata  <= '0;
      read   <= 1'b0;
      write  <= 1'b0;
      timer  <= '0;
    end else begin
      read  <= capture;
      write <= write_inc;
      timer <= ((state == SEND) || (state == RECV)) ? timer + 1'b1 : '0;
      if (capture) begin
        sample <= '{left: readdata_left, right: readdata_right};
      end else if ((state == RECV) && proc_in_valid) begin
        sample <= '{left: proc_in_left, right: proc_in_right};
      end
      if (state == WRITE) begin
        wdata <= mute ? '0 : sample;
      end
    end
  end

  assign proc_out_left   = sample.left;
  assign proc_out_right  = sample.right;
  assign writedata_left  = wdata.left;
  assign writedata_right = wdata.right;

  sat_counter #(
    .WIDTH    (CNT_W),
    .SATURATE (1'b0)
  ) u_sample_cnt (
    .clk    (CLOCK_50),
    .resetn (resetn),
    .clear  (1'b0),
    .inc    (write_inc),
    .count  (sample_count)
  );

  sat_counter #(
    .WIDTH    (CNT_W),
    .SATURATE (1'b1)
  ) u_drop_cnt (
    .clk    (CLOCK_50),
    .resetn (resetn),
    .clear  (1'b0),
    .inc    (drop_inc),
    .count  (drop_count)
  );

endmodule

// File: tb/tb_audio_stream_sequencer.sv
// Directed bench for audio_stream_sequencer with a short timeout and narrow
// counters so saturation and wrap are reached quickly.
module tb_audio_stream_sequencer;
  import audio_pkg::*;

  localparam int unsigned DATA_W  = 24;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNT_W   = 4;

  logic              clk = 1'b0;
  logic              resetn, enable, bypass, mute;
  logic              read_ready, read, write_ready, write;
  logic [DATA_W-1:0] readdata_left, readdata_right;
  logic [DATA_W-1:0] writedata_left, writedata_right;
  logic              proc_out_valid, proc_out_ready, proc_in_valid, proc_in_ready;
  logic [DATA_W-1:0] proc_out_left, proc_out_right, proc_in_left, proc_in_right;
  logic              busy;
  logic [CNT_W-1:0]  sample_count, drop_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned rd_cnt   = 0;
  int unsigned wr_cnt   = 0;
  logic        overlap  = 1'b0;

  always #5 clk = ~clk;

  audio_stream_sequencer #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .CLOCK_50        (clk),
    .resetn          (resetn),
    .enable          (enable),
    .bypass          (bypass),
    .mute            (mute),
    .read_ready      (read_ready),
    .readdata_left   (readdata_left),
    .readdata_right  (readdata_right),
    .read            (read),
    .write_ready     (write_ready),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .proc_out_valid  (proc_out_valid),
    .proc_out_ready  (proc_out_ready),
    .proc_out_left   (proc_out_left),
    .proc_out_right  (proc_out_right),
    .proc_in_valid   (proc_in_valid),
    .proc_in_ready   (proc_in_ready),
    .proc_in_left    (proc_in_left),
    .proc_in_right   (proc_in_right),
    .busy            (busy),
    .sample_count    (sample_count),
    .drop_count      (drop_count)
  );

  always @(negedge clk) begin
    if (read)  rd_cnt++;
    if (write) wr_cnt++;
    if (read && write) overlap = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start a DSP transaction that never gets a result; returns once back in IDLE.
  task automatic run_timeout();
    read_ready = 1'b1;
    step();
    read_ready = 1'b0;
    step(8);
  endtask

  stereo_t     vec;
  logic [DATA_W-1:0] dsp_l, dsp_r;
  int unsigned wr0, rd0, exp_drop;

  initial begin
    resetn = 1'b0; enable = 1'b0; bypass = 1'b0; mute = 1'b0;
    read_ready = 1'b0; write_ready = 1'b0; proc_out_ready = 1'b0; proc_in_valid = 1'b0;
    readdata_left = '0; readdata_right = '0; proc_in_left = '0; proc_in_right = '0;
    step(2);
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", proc_out_valid, 0);
    check("rst_in_ready", proc_in_ready, 0);
    check("rst_samples", sample_count, 0);
    check("rst_drops", drop_count, 0);
    resetn = 1'b1;
    enable = 1'b1;
    step();

    // Bypass loopback
    bypass = 1'b1; write_ready = 1'b1;
    vec = '{left: 24'h123456, right: 24'hABCDEF};
    readdata_left = vec.left; readdata_right = vec.right;
    read_ready = 1'b1;
    step();
    read_ready = 1'b0;
    check("byp_read", read, 1);
    check("byp_busy", busy, 1);
    step();
    check("byp_write", write, 1);
    check("byp_read_low", read, 0);
    check("byp_wl", writedata_left, 24'h123456);
    check("byp_wr", writedata_right, 24'hABCDEF);
    check("byp_count", sample_count, 1);
    step();
    check("byp_write_low", write, 0);
    check("byp_idle", busy, 0);

    // DSP path, inverting DSP with 3-cycle latency
    bypass = 1'b0;
    readdata_left = 24'h000010; readdata_right = 24'h000020;
    read_ready = 1'b1;
    step();
    read_ready = 1'b0;
    readdata_left = '0; readdata_right = '0;
    check("dsp_out_valid", proc_out_valid, 1);
    check("dsp_out_l", proc_out_left, 24'h000010);
    step(2);
    check("dsp_hold_valid", proc_out_valid, 1);
    check("dsp_hold_l", proc_out_left, 24'h000010);
    check("dsp_hold_r", proc_out_right, 24'h000020);
    proc_out_ready = 1'b1;
    dsp_l = ~proc_out_left; dsp_r = ~proc_out_right;
    step();
    proc_out_ready = 1'b0;
    check("dsp_in_ready", proc_in_ready, 1);
    check("dsp_out_valid_low", proc_out_valid, 0);
    step(2);
    proc_in_valid = 1'b1; proc_in_left = dsp_l; proc_in_right = dsp_r;
    step();
    proc_in_valid = 1'b0;
    check("dsp_in_ready_low", proc_in_ready, 0);
    step();
    check("dsp_write", write, 1);
    check("dsp_wl", writedata_left, 24'hFFFFEF);
    check("dsp_wr", writedata_right, 24'hFFFFDF);
    check("dsp_count", sample_count, 2);
    step();

    // Timeout: DSP never answers
    proc_out_ready = 1'b1;
    wr0 = wr_cnt;
    read_ready = 1'b1;
    step();
    read_ready = 1'b0;
    step(7);
    check("to_busy_before", busy, 1);
    step();
    check("to_idle", busy, 0);
    check("to_drops", drop_count, 1);
    check("to_no_write", wr_cnt - wr0, 0);
    exp_drop = 1;
    for (int unsigned i = 0; i < 20; i++) begin
      run_timeout();
      exp_drop = (exp_drop < 15) ? exp_drop + 1 : 15;
      check("to_sat", drop_count, exp_drop);
    end
    check("to_sat_final", drop_count, 4'hF);
    check("to_count_kept", sample_count, 2);
    proc_out_ready = 1'b0;

    // Mute with DAC backpressure
    bypass = 1'b1; mute = 1'b1; write_ready = 1'b0;
    readdata_left = 24'h555555; readdata_right = 24'h2AAAAA;
    read_ready = 1'b1;
    step();
    read_ready = 1'b0;
    wr0 = wr_cnt;
    step(20);
    check("mute_wait_busy", busy, 1);
    check("mute_no_write", wr_cnt - wr0, 0);
    write_ready = 1'b1;
    step();
    check("mute_write", write, 1);
    check("mute_wl", writedata_left, 0);
    check("mute_wr", writedata_right, 0);
    check("mute_count", sample_count, 3);
    mute = 1'b0;
    step();

    // Reset while waiting for the DSP result
    bypass = 1'b0; proc_out_ready = 1'b1;
    readdata_left = 24'h314159; readdata_right = 24'h271828;
    read_ready = 1'b1;
    step();
    read_ready = 1'b0;
    step();
    check("rr_in_ready", proc_in_ready, 1);
    wr0 = wr_cnt;
    resetn = 1'b0;
    proc_in_valid = 1'b1; proc_in_left = 24'h777777; proc_in_right = 24'h777777;
    step();
    check("rr_read", read, 0);
    check("rr_write", write, 0);
    check("rr_busy", busy, 0);
    check("rr_in_ready0", proc_in_ready, 0);
    check("rr_out_valid", proc_out_valid, 0);
    check("rr_out_l", proc_out_left, 0);
    check("rr_samples", sample_count, 0);
    check("rr_drops", drop_count, 0);
    resetn = 1'b1;
    step();
    proc_in_valid = 1'b0; proc_out_ready = 1'b0;
    step(2);
    check("rr_no_write", wr_cnt - wr0, 0);
    check("rr_still_idle", busy, 0);
    bypass = 1'b1;
    readdata_left = 24'h0F0F0F; readdata_right = 24'hF0F0F0;
    read_ready = 1'b1;
    step();
    read_ready = 1'b0;
    step();
    check("rr_resume_write", write, 1);
    check("rr_resume_wl", writedata_left, 24'h0F0F0F);
    check("rr_resume_wr", writedata_right, 24'hF0F0F0);
    check("rr_resume_count", sample_count, 1);
    step();

    // Back-to-back bypass samples through the counter wrap, then enable drop
    rd0 = rd_cnt;
    read_ready = 1'b1;
    step(28);
    check("wrap_at_max", sample_count, 15);
    step();
    enable = 1'b0;
    step();
    check("wrap_write", write, 1);
    check("wrap_zero", sample_count, 0);
    check("wrap_reads", rd_cnt - rd0, 15);
    step(3);
    check("en_off_idle", busy, 0);
    check("en_off_no_read", rd_cnt - rd0, 15);
    check("en_off_count", sample_count, 0);
    read_ready = 1'b0;
    enable = 1'b1;
    step();

    check("rw_exclusive", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/audio_stream_sequencer.md
Name: audio_stream_sequencer

Overview:
- Sequences the audio codec FIFO handshake for one stereo sample pair at a time: pop from the ADC, hand to an external processing stage, push the result to the DAC.
- Sits between audio_codec and a user DSP block in the top level, replacing ad-hoc read/write glue.
- Adds bypass, mute, a processing timeout and sample/drop statistics.

Parameters:
- DATA_W, 24, sample width per channel (codec word).
- TIMEOUT, 4096, max CLOCK_50 cycles to wait for the processed result before the sample is dropped.
- CNT_W, 16, width of the sample and drop counters.

Ports:
- CLOCK_50  in  1  system clock; all logic is single-clock on its rising edge.
- resetn  in  1  synchronous, active-low reset.
- enable  in  1  allows new transactions to start.
- bypass  in  1  skip the processing stage; sampled at capture.
- mute  in  1  write zeros to the DAC; sampled at write.
- read_ready  in  1  codec ADC FIFO non-empty.
- readdata_left  in  DATA_W  ADC left channel, show-ahead head of the FIFO.
- readdata_right  in  DATA_W  ADC right channel, show-ahead head of the FIFO.
- read  out  1  one-cycle pop strobe to the codec.
- write_ready  in  1  codec DAC FIFO has space.
- write  out  1  one-cycle push strobe to the codec.
- writedata_left  out  DATA_W  DAC left channel.
- writedata_right  out  DATA_W  DAC right channel.
- proc_out_valid  out  1  captured sample offered to the DSP.
- proc_out_ready  in  1  DSP accepts the offered sample.
- proc_out_left  out  DATA_W  left channel offered to the DSP.
- proc_out_right  out  DATA_W  right channel offered to the DSP.
- proc_in_valid  in  1  DSP result valid.
- proc_in_ready  out  1  sequencer accepts the DSP result.
- proc_in_left  in  DATA_W  DSP result, left channel.
- proc_in_right  in  DATA_W  DSP result, right channel.
- busy  out  1  state != IDLE.
- sample_count  out  CNT_W  samples written to the DAC; wraps.
- drop_count  out  CNT_W  samples dropped on timeout; saturates at all-ones.

Behaviour:
- Reset (resetn low at a clock edge):
  - State goes to IDLE.
  - read, write, proc_out_valid and proc_in_ready are 0.
  - All data registers and both counters are 0.
  - Reset applies mid-transaction too: the pending sample is discarded and no strobe is issued on that edge.
- States: IDLE, SEND, RECV, WRITE.
- IDLE:
  - When enable=1 and read_ready=1: capture readdata_left/right into a sample register, pulse read for exactly one cycle, latch bypass.
  - Go to WRITE if bypass=1, otherwise to SEND.
  - Otherwise stay in IDLE with read=0.
- SEND:
  - proc_out_valid=1, proc_out_left/right driven from the sample register, held stable until proc_out_ready.
  - On a cycle with valid and ready both 1, go to RECV.
- RECV:
  - proc_in_ready=1.
  - When proc_in_valid=1: load proc_in_left/right into the sample register and go to WRITE.
- Timeout:
  - A timer clears on entry to SEND and counts every cycle spent in SEND or RECV.
  - When it reaches TIMEOUT-1 without the RECV handshake completing: drop the sample, increment drop_count (saturating), return to IDLE.
  - If the handshake completes on that same cycle, the handshake wins and no drop is counted.
- WRITE:
  - writedata_left/right = sample register, or 0 when mute=1.
  - When write_ready=1: pulse write for one cycle, increment sample_count (wraps from all-ones to 0), go to IDLE.
  - There is no timeout in WRITE.
- Outside WRITE, writedata holds its last value.
- read and write are never both 1 in the same cycle.
- Minimum cycle time is one sample per 2 cycles (bypass: IDLE→WRITE→IDLE with write_ready already 1).
- enable deasserted mid-transaction: the current sample completes; no new capture follows.
- Back-to-back operation: IDLE may capture a new sample on the cycle after the write pulse.

Decomposition:
- Shared package audio_pkg holds:
  - the DATA_W default;
  - the state encoding (localparams for IDLE, SEND, RECV, WRITE);
  - the stereo sample pair typedef.
- One sub-module, sat_counter (width parameter, inc, clear, saturate flag), used for drop_count and, with saturation off, for sample_count.

Test Plan:
- Bypass loopback: bypass=1, write_ready=1, read_ready pulses with L=24'h123456, R=24'hABCDEF. Required: one read pulse, then a write pulse 1 cycle later with the same data; sample_count=1.
- DSP path: DSP inverts the samples with 3-cycle latency, input L=24'h000010. Required: write carries 24'hFFFFEF; proc_out data is stable while proc_out_ready is low.
- Timeout: TIMEOUT=8, DSP never asserts proc_in_valid. Required: FSM back in IDLE 8 cycles after entering SEND; drop_count=1; no write pulse. Repeat 2^CNT_W+5 times: drop_count stays at all-ones.
- Mute and backpressure: mute=1, write_ready held low for 20 cycles. Required: FSM waits in WRITE; the write pulse lands on the first write_ready cycle with writedata=0.
- Reset mid-RECV: resetn=0 for one edge. Required: all outputs 0 on the next cycle and no write pulse; normal operation resumes after resetn=1.
- Wrap: force 65535 bypass samples plus 1. Required: sample_count goes 65535→0; read and write never high together (assertion).
